// File: rtl/common_pkg.sv
// Shared front-end definitions: fetch FSM encoding and the default boot address.
package common;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pipes_pkg.sv
// Inter-stage pipeline payloads; fetch_data_t is what fetch hands to decode.
package pipes;

   typedef struct packed {
      logic        valid;
      logic        bubble;
      logic [63:0] pc;
      logic [31:0] raw_instr;
      logic [31:0] iresp_data;
   } fetch_data_t;

   function automatic fetch_data_t fetch_bubble();
      fetch_data_t f;
      f        = '0;
      f.bubble = 1'b1;
      return f;
   endfunction

   function automatic fetch_data_t fetch_word(input logic [63:0] pc, input logic [31:0] instr);
      fetch_data_t f;
      f.valid      = 1'b1;
      f.bubble     = 1'b0;
      f.pc         = pc;
      f.raw_instr  = instr;
      f.iresp_data = instr;
      return f;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding slot for a word that returned while the pipeline was stalled.
module fetch_buffer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        load_i,
   input  logic [63:0] pc_i,
   input  logic [31:0] instr_i,
   output logic [63:0] pc_o,
   output logic [31:0] instr_o
);

   logic [63:0] pc_q;
   logic [31:0] instr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q    <= '0;
         instr_q <= '0;
      end else if (clr_i) begin
         pc_q    <= '0;
         instr_q <= '0;
      end else if (load_i) begin
         pc_q    <= pc_i;
         instr_q <= instr_i;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding bus request, stall buffering and
// redirect handling with stale-response dropping.
module fetch
   import common::*;
   import pipes::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output fetch_data_t dataF
);

   fetch_state_e state_q;
   logic [63:0]  pc_q;
   logic [63:0]  tgt_q;
   logic         ireq_valid_q;
   fetch_data_t  dataF_q;

   logic         dok;
   logic         buf_load;
   logic         buf_clr;
   logic [63:0]  buf_pc;
   logic [31:0]  buf_instr;

   // A response only counts while our request is actually on the bus.
   always_comb begin
      dok      = iresp_data_ok & ireq_valid_q;
      buf_load = (state_q == ST_REQ) & dok & stall & ~redirect;
      buf_clr  = redirect | ((state_q == ST_HOLD) & ~stall);
   end

   fetch_buffer u_buf (
      .clk_i   (clk),
      .rst_ni  (reset),
      .clr_i   (buf_clr),
      .load_i  (buf_load),
      .pc_i    (pc_q),
      .instr_i (iresp_data),
      .pc_o    (buf_pc),
      .instr_o (buf_instr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_REQ;
         pc_q         <= RESET_PC;
         tgt_q        <= '0;
         ireq_valid_q <= 1'b0;
         dataF_q      <= '0;
      end else if (redirect) begin
         dataF_q      <= fetch_bubble();
         ireq_valid_q <= 1'b1;
         case (state_q)
            ST_REQ: begin
               // With nothing in flight the target can be requested directly.
               if (dok || !ireq_valid_q) begin
                  pc_q <= redirect_pc;
               end else begin
                  state_q <= ST_DROP;
                  tgt_q   <= redirect_pc;
               end
            end
            ST_DROP: begin
               if (dok) begin
                  state_q <= ST_REQ;
                  pc_q    <= redirect_pc;
               end else begin
                  tgt_q <= redirect_pc;
               end
            end
            default: begin
               state_q <= ST_REQ;
               pc_q    <= redirect_pc;
            end
         endcase
      end else begin
         case (state_q)
            ST_REQ: begin
               if (dok && stall) begin
                  state_q      <= ST_HOLD;
                  pc_q         <= pc_q + 64'd4;
                  ireq_valid_q <= 1'b0;
               end else if (dok) begin
                  dataF_q      <= fetch_word(pc_q, iresp_data);
                  pc_q         <= pc_q + 64'd4;
                  ireq_valid_q <= 1'b1;
               end else begin
                  ireq_valid_q <= 1'b1;
                  if (!stall) dataF_q <= fetch_bubble();
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  dataF_q      <= fetch_word(buf_pc, buf_instr);
                  state_q      <= ST_REQ;
                  ireq_valid_q <= 1'b1;
               end
            end
            ST_DROP: begin
               if (!stall) dataF_q <= fetch_bubble();
               if (dok) begin
                  state_q <= ST_REQ;
                  pc_q    <= tgt_q;
               end
            end
            default: begin
               state_q      <= ST_REQ;
               ireq_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ireq_valid = ireq_valid_q;
   assign ireq_addr  = pc_q;
   assign dataF      = dataF_q;

endmodule
